hdmi_tx_sequencer: RTL

//   Bring-up and frame sequencer for the HDMI test-pattern transmit path.

---
 rtl/hdmi_tx_sequencer_if.sv | 25 ++
 rtl/hdmi_tx_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_sequencer_if.sv
// rtl/hdmi_tx_sequencer_if.sv - control inputs and video timing outputs of the HDMI TX sequencer
interface hdmi_tx_sequencer_if;
   logic        pll_locked;
   logic        pat_next_req;
   logic        auto_cycle;
   logic        ser_reset;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [11:0] x;
   logic [11:0] y;
   logic        frame_start;
   logic [3:0]  pattern_sel;
   logic [1:0]  state;

   modport master (
      input  pll_locked, pat_next_req, auto_cycle,
      output ser_reset, hsync, vsync, de, x, y, frame_start, pattern_sel, state
   );

   modport slave (
      output pll_locked, pat_next_req, auto_cycle,
      input  ser_reset, hsync, vsync, de, x, y, frame_start, pattern_sel, state
   );
endinterface

// File: rtl/hdmi_tx_sequencer.sv
// rtl/hdmi_tx_sequencer.sv - HDMI TX bring-up FSM, video timing and pattern scheduler
// Optional SEQ_LOCK_DEBOUNCE_EN: require 256 consecutive synced-lock cycles before leaving WAIT_LOCK.
module hdmi_tx_sequencer #(
   parameter int   H_ACTIVE           = 640,
   parameter int   H_FP               = 16,
   parameter int   H_SYNC             = 96,
   parameter int   H_BP               = 48,
   parameter int   V_ACTIVE           = 480,
   parameter int   V_FP               = 10,
   parameter int   V_SYNC             = 2,
   parameter int   V_BP               = 33,
   parameter logic HS_POL             = 1'b0,
   parameter logic VS_POL             = 1'b0,
   parameter int   SER_RST_CYCLES     = 16,
   parameter int   BLANK_FRAMES       = 2,
   parameter int   NUM_PATTERNS       = 4,
   parameter int   FRAMES_PER_PATTERN = 120
) (
   input logic                 sysclk,
   input logic                 reset,
   hdmi_tx_sequencer_if.master bus
);
   localparam logic [1:0]  ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0]  ST_SER_RST   = 2'd1;
   localparam logic [1:0]  ST_BLANK     = 2'd2;
   localparam logic [1:0]  ST_ACTIVE    = 2'd3;

   localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [7:0]  RST_LAST   = 8'(SER_RST_CYCLES - 1);
   localparam logic [7:0]  BLANK_LAST = 8'(BLANK_FRAMES - 1);
   localparam logic [3:0]  PAT_LAST   = 4'(NUM_PATTERNS - 1);
   localparam logic [15:0] DWELL_LAST = 16'(FRAMES_PER_PATTERN - 1);

   logic        lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
   logic [1:0]  state_q, state_d;
   logic [7:0]  rst_cnt_q, rst_cnt_d;
   logic [7:0]  blank_cnt_q, blank_cnt_d;
   logic [11:0] h_q, h_d, v_q, v_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic        frame_start_q, frame_start_d, ser_reset_q, ser_reset_d;
   logic [3:0]  pattern_q, pattern_d;
   logic        pending_q, pending_d;
   logic [15:0] dwell_q, dwell_d;
   logic        running, frame_end, frame_boundary, advance;
`ifdef SEQ_LOCK_DEBOUNCE_EN
   logic [7:0]  lock_cnt_q, lock_cnt_d;
`endif

   assign running        = lock_s2_q && (state_q == ST_BLANK || state_q == ST_ACTIVE);
   assign frame_end      = (h_q == H_LAST) && (v_q == V_LAST);
   assign frame_boundary = running && (h_q == 12'd0) && (v_q == 12'd0);

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) state_q <= ST_WAIT_LOCK;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!lock_s2_q) begin
         state_d = ST_WAIT_LOCK;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
`ifdef SEQ_LOCK_DEBOUNCE_EN
               if (lock_cnt_q == 8'hFF) state_d = ST_SER_RST;
`else
               state_d = ST_SER_RST;
`endif
            end
            ST_SER_RST: if (rst_cnt_q == RST_LAST) state_d = ST_BLANK;
            // Leave BLANK on the last pixel so the first ACTIVE frame starts at h=v=0.
            ST_BLANK:   if (frame_end && blank_cnt_q == BLANK_LAST) state_d = ST_ACTIVE;
            default:    state_d = state_q;
         endcase
      end
   end

   always_comb begin
      lock_s1_d   = bus.pll_locked;
      lock_s2_d   = lock_s1_q;
      rst_cnt_d   = (state_q == ST_SER_RST) ? rst_cnt_q + 8'd1 : 8'd0;
      h_d         = 12'd0;
      v_d         = 12'd0;
      blank_cnt_d = 8'd0;
      if (running) begin
         h_d         = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
         v_d         = (h_q != H_LAST) ? v_q : ((v_q == V_LAST) ? 12'd0 : v_q + 12'd1);
         blank_cnt_d = (state_q == ST_BLANK && frame_end) ? blank_cnt_q + 8'd1 : blank_cnt_q;
      end
`ifdef SEQ_LOCK_DEBOUNCE_EN
      lock_cnt_d = (state_q == ST_WAIT_LOCK && lock_s2_q) ? lock_cnt_q + 8'd1 : 8'd0;
`endif

      x_d           = h_q;
      y_d           = v_q;
      de_d          = lock_s2_q && (state_q == ST_ACTIVE) && (h_q < H_ACT) && (v_q < V_ACT);
      hsync_d       = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : !HS_POL;
      vsync_d       = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : !VS_POL;
      frame_start_d = frame_boundary;
      ser_reset_d   = !(state_d == ST_BLANK || state_d == ST_ACTIVE);

      // A request seen on the boundary cycle itself is carried into the next frame.
      advance   = frame_boundary && (state_q == ST_ACTIVE) &&
                  (pending_q || (bus.auto_cycle && dwell_q == DWELL_LAST));
      pattern_d = pattern_q;
      pending_d = pending_q || bus.pat_next_req;
      dwell_d   = dwell_q;
      if (advance) begin
         pattern_d = (pattern_q == PAT_LAST) ? 4'd0 : pattern_q + 4'd1;
         pending_d = bus.pat_next_req;
         dwell_d   = 16'd0;
      end else if (frame_boundary && state_q == ST_ACTIVE) begin
         dwell_d = dwell_q + 16'd1;
      end
      if (!bus.auto_cycle || !lock_s2_q) dwell_d = 16'd0;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         lock_s1_q     <= 1'b0;
         lock_s2_q     <= 1'b0;
         rst_cnt_q     <= 8'd0;
         blank_cnt_q   <= 8'd0;
         h_q           <= 12'd0;
         v_q           <= 12'd0;
         x_q           <= 12'd0;
         y_q           <= 12'd0;
         hsync_q       <= !HS_POL;
         vsync_q       <= !VS_POL;
         de_q          <= 1'b0;
         frame_start_q <= 1'b0;
         ser_reset_q   <= 1'b1;
         pattern_q     <= 4'd0;
         pending_q     <= 1'b0;
         dwell_q       <= 16'd0;
`ifdef SEQ_LOCK_DEBOUNCE_EN
         lock_cnt_q    <= 8'd0;
`endif
      end else begin
         lock_s1_q     <= lock_s1_d;
         lock_s2_q     <= lock_s2_d;
         rst_cnt_q     <= rst_cnt_d;
         blank_cnt_q   <= blank_cnt_d;
         h_q           <= h_d;
         v_q           <= v_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         frame_start_q <= frame_start_d;
         ser_reset_q   <= ser_reset_d;
         pattern_q     <= pattern_d;
         pending_q     <= pending_d;
         dwell_q       <= dwell_d;
`ifdef SEQ_LOCK_DEBOUNCE_EN
         lock_cnt_q    <= lock_cnt_d;
`endif
      end
   end

   assign bus.ser_reset   = ser_reset_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.de          = de_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.frame_start = frame_start_q;
   assign bus.pattern_sel = pattern_q;
   assign bus.state       = state_q;
endmodule
